// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   state_t      : FSM state encoding for mem_access
//   SZ_*         : access size codes carried on ex_size
//   store_strobe : byte-enable pattern for a store of a given size/offset
//   is_misaligned: true when the size/offset pair cannot be issued as one access
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BEF  = 3'd1,
    ACCESS    = 3'd2,
    SENDING   = 3'd3,
    WAIT_SEND = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << lo;
      SZ_HALF: s = 4'b0011 << lo;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Size code 11 is treated like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = lo[0];
      default: m = |lo;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction and sign/zero extension (purely combinational).
//   rdata       : word returned by data memory
//   addr_lo     : byte offset of the access inside the word
//   size        : SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned : zero-extend instead of sign-extend
//   result      : extended load value
module load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: result = is_unsigned ? {{(XLEN-8){1'b0}}, lane_b}
                                    : {{(XLEN-8){lane_b[7]}}, lane_b};
      SZ_HALF: result = is_unsigned ? {{(XLEN-16){1'b0}}, lane_h}
                                    : {{(XLEN-16){lane_h[15]}}, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage between execute and writeBack.
// Captures one op from execute, performs an optional data-memory load/store
// (held until mem_ack), then offers the result to writeBack.
//   clk, rst                     : clock, async active-high reset
//   startSig                     : leaves IDLE
//   beforePipReadyToSend         : execute offers an op
//   nextPipReadyToRcv            : writeBack accepts
//   curPipReadyToRcv/Send        : handshake outputs of this stage
//   ex_*                         : op fields from execute
//   mem_*                        : data-memory request/response
//   wb_*, wb_en_*                : result to writeBack and capture strobes
//   bp_idx, bp_val               : bypass of the held result
//   misalign                     : one-cycle pulse when a misaligned access is captured
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startSig,
  input  logic               beforePipReadyToSend,
  input  logic               nextPipReadyToRcv,
  output logic               curPipReadyToRcv,
  output logic               curPipReadyToSend,
  input  logic               ex_valid,
  input  logic [REG_IDX-1:0] ex_idx,
  input  logic [XLEN-1:0]    ex_val,
  input  logic [XLEN-1:0]    ex_storeData,
  input  logic               ex_isLoad,
  input  logic               ex_isStore,
  input  logic [1:0]         ex_size,
  input  logic               ex_unsigned,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [3:0]         mem_wstrb,
  input  logic               mem_ack,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               wb_valid,
  output logic [REG_IDX-1:0] wb_idx,
  output logic [XLEN-1:0]    wb_val,
  output logic               wb_en_valid,
  output logic               wb_en_idx,
  output logic               wb_en_data,
  output logic [REG_IDX-1:0] bp_idx,
  output logic [XLEN-1:0]    bp_val,
  output logic               misalign
);

  function automatic logic [XLEN-1:0] lane_replicate(input logic [1:0] size,
                                                     input logic [XLEN-1:0] data);
    logic [XLEN-1:0] r;
    case (size)
      SZ_BYTE: r = {(XLEN/8){data[7:0]}};
      SZ_HALF: r = {(XLEN/16){data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  state_t             state;
  logic               sending, capture, handoff;
  logic               ex_mem, ex_mis, go_access, ack_load;
  logic [REG_IDX-1:0] idx_p1;
  logic [XLEN-1:0]    addr_p1, sdata_p1, load_res;
  logic               load_p1, store_p1, uns_p1;
  logic [1:0]         size_p1;

  // ---- stage 0: handshake and capture decision ----
  assign sending           = (state == SENDING) || (state == WAIT_SEND);
  assign curPipReadyToSend = sending;
  assign curPipReadyToRcv  = (state == WAIT_BEF) || (sending && nextPipReadyToRcv);
  assign capture           = curPipReadyToRcv && beforePipReadyToSend;
  assign handoff           = sending && nextPipReadyToRcv;
  assign wb_en_valid       = handoff;
  assign wb_en_idx         = handoff;
  assign wb_en_data        = handoff;

  assign ex_mem    = ex_isLoad || ex_isStore;
  assign ex_mis    = ex_mem && is_misaligned(ex_size, ex_val[1:0]);
  assign go_access = ex_mem && !ex_mis;
  assign misalign  = capture && ex_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
    end else begin
      if (capture)
        wb_valid <= ex_valid && !ex_isStore && !ex_mis;
      case (state)
        IDLE:   if (startSig) state <= WAIT_BEF;
        ACCESS: if (mem_ack) state <= SENDING;
        WAIT_BEF, SENDING, WAIT_SEND: begin
          if (capture)
            state <= go_access ? ACCESS : SENDING;
          else if (state != WAIT_BEF)
            state <= nextPipReadyToRcv ? WAIT_BEF : WAIT_SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage 1: captured op, memory access, result ----
  // Datapath registers carry no reset; every consumer is qualified by state.
  assign ack_load = (state == ACCESS) && mem_ack && load_p1;

  always_ff @(posedge clk) begin
    if (capture) begin
      idx_p1   <= ex_idx;
      addr_p1  <= ex_val;
      sdata_p1 <= ex_storeData;
      load_p1  <= ex_isLoad;
      store_p1 <= ex_isStore;
      size_p1  <= ex_size;
      uns_p1   <= ex_unsigned;
      wb_val   <= ex_val;
    end else if (ack_load) begin
      wb_val   <= load_res;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (mem_rdata),
    .addr_lo     (addr_p1[1:0]),
    .size        (size_p1),
    .is_unsigned (uns_p1),
    .result      (load_res)
  );

  assign mem_req   = (state == ACCESS);
  assign mem_we    = mem_req && store_p1;
  assign mem_addr  = {addr_p1[XLEN-1:2], 2'b00};
  assign mem_wdata = lane_replicate(size_p1, sdata_p1);
  assign mem_wstrb = mem_we ? store_strobe(size_p1, addr_p1[1:0]) : 4'b0000;

  // ---- stage 2: writeBack and bypass outputs ----
  assign wb_idx = idx_p1;
  assign bp_idx = (sending && wb_valid && (idx_p1 != '0)) ? idx_p1 : '0;
  assign bp_val = (sending && wb_valid && (idx_p1 != '0)) ? wb_val : '0;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        startSig, beforePipReadyToSend, nextPipReadyToRcv;
  logic        curPipReadyToRcv, curPipReadyToSend;
  logic        ex_valid, ex_isLoad, ex_isStore, ex_unsigned;
  logic [4:0]  ex_idx;
  logic [31:0] ex_val, ex_storeData;
  logic [1:0]  ex_size;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_en_valid, wb_en_idx, wb_en_data, misalign;
  logic [4:0]  wb_idx, bp_idx;
  logic [31:0] wb_val, bp_val;

  int checks = 0;
  int errors = 0;

  mem_access #(.XLEN(32), .REG_IDX(5)) dut (
    .clk(clk), .rst(rst), .startSig(startSig),
    .beforePipReadyToSend(beforePipReadyToSend), .nextPipReadyToRcv(nextPipReadyToRcv),
    .curPipReadyToRcv(curPipReadyToRcv), .curPipReadyToSend(curPipReadyToSend),
    .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_val(ex_val), .ex_storeData(ex_storeData),
    .ex_isLoad(ex_isLoad), .ex_isStore(ex_isStore), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val),
    .wb_en_valid(wb_en_valid), .wb_en_idx(wb_en_idx), .wb_en_data(wb_en_data),
    .bp_idx(bp_idx), .bp_val(bp_val), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: loads, strobes, lane data and alignment from plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [1:0] sz, input logic uns);
    int lane;
    logic [31:0] v;
    lane = int'(addr % 4);
    if (sz == 2'd0) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_strb(input logic [1:0] sz, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    if (sz == 2'd0) return 32'(1 << lane);
    if (sz == 2'd1) return 32'(3 << lane);
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    if (sz == 2'd1) return (lane % 2) == 1;
    if (sz == 2'd2) return lane != 0;
    return 1'b0;
  endfunction

  // Runs one op starting in WAIT_BEF and ending back in WAIT_BEF.
  task automatic do_op(input string tag, input logic v, input logic [4:0] idx,
                       input logic [31:0] val, input logic [31:0] sd, input logic ld,
                       input logic st, input logic [1:0] sz, input logic uns,
                       input int ack_n, input logic [31:0] rd, input int stall);
    logic mem, mis, exp_wbv, chk_val;
    logic [31:0] exp_val, exp_bpv;
    logic [4:0]  exp_bpi;
    mem     = ld || st;
    mis     = mem && ref_mis(sz, val);
    exp_wbv = v && !st && !mis;
    exp_val = (ld && !mis) ? ref_load(rd, val, sz, uns) : val;
    chk_val = exp_wbv || !mem;
    exp_bpi = (exp_wbv && idx != 5'd0) ? idx : 5'd0;
    exp_bpv = (exp_wbv && idx != 5'd0) ? exp_val : 32'd0;

    chk(tag, "rdy_in", 32'(curPipReadyToRcv), 32'd1);
    ex_valid = v; ex_idx = idx; ex_val = val; ex_storeData = sd;
    ex_isLoad = ld; ex_isStore = st; ex_size = sz; ex_unsigned = uns;
    beforePipReadyToSend = 1'b1;
    #1;
    chk(tag, "misalign", 32'(misalign), 32'(mis));
    step();
    beforePipReadyToSend = 1'b0;

    if (mem && !mis) begin
      for (int c = 1; c <= ack_n; c++) begin
        chk(tag, "mem_req", 32'(mem_req), 32'd1);
        chk(tag, "mem_addr", mem_addr, val & 32'hFFFF_FFFC);
        chk(tag, "mem_we", 32'(mem_we), 32'(st));
        chk(tag, "mem_wstrb", 32'(mem_wstrb), st ? ref_strb(sz, val) : 32'd0);
        if (st) chk(tag, "mem_wdata", mem_wdata, ref_wdata(sz, sd));
        chk(tag, "bp_val_acc", bp_val, 32'd0);
        if (c == ack_n) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        step();
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
    chk(tag, "mem_req_off", 32'(mem_req), 32'd0);
    chk(tag, "rdy_send", 32'(curPipReadyToSend), 32'd1);
    chk(tag, "wb_valid", 32'(wb_valid), 32'(exp_wbv));
    chk(tag, "wb_idx", 32'(wb_idx), 32'(idx));
    if (chk_val) chk(tag, "wb_val", wb_val, exp_val);
    chk(tag, "bp_idx", 32'(bp_idx), 32'(exp_bpi));
    chk(tag, "bp_val", bp_val, exp_bpv);

    nextPipReadyToRcv = (stall == 0);
    #1;
    chk(tag, "wb_en", 32'({wb_en_valid, wb_en_idx, wb_en_data}), (stall == 0) ? 32'd7 : 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      chk(tag, "hold_send", 32'(curPipReadyToSend), 32'd1);
      chk(tag, "hold_rcv", 32'(curPipReadyToRcv), 32'd0);
      chk(tag, "hold_en", 32'({wb_en_valid, wb_en_idx, wb_en_data}), 32'd0);
      chk(tag, "hold_bp", 32'(bp_idx), 32'(exp_bpi));
      if (chk_val) chk(tag, "hold_val", wb_val, exp_val);
    end
    if (stall > 0) begin
      nextPipReadyToRcv = 1'b1;
      #1;
      chk(tag, "wb_en_late", 32'({wb_en_valid, wb_en_idx, wb_en_data}), 32'd7);
    end
    step();
    chk(tag, "back_rcv", 32'(curPipReadyToRcv), 32'd1);
    chk(tag, "back_send", 32'(curPipReadyToSend), 32'd0);
    chk(tag, "back_en", 32'(wb_en_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; startSig = 1'b0; beforePipReadyToSend = 1'b0; nextPipReadyToRcv = 1'b1;
    ex_valid = 1'b0; ex_idx = '0; ex_val = '0; ex_storeData = '0;
    ex_isLoad = 1'b0; ex_isStore = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    step();
    chk("reset", "mem_req", 32'(mem_req), 32'd0);
    chk("reset", "mem_we", 32'(mem_we), 32'd0);
    chk("reset", "mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset", "wb_valid", 32'(wb_valid), 32'd0);
    chk("reset", "wb_en", 32'({wb_en_valid, wb_en_idx, wb_en_data}), 32'd0);
    chk("reset", "misalign", 32'(misalign), 32'd0);
    chk("reset", "rdy", 32'({curPipReadyToSend, curPipReadyToRcv}), 32'd0);
    chk("reset", "bp_idx", 32'(bp_idx), 32'd0);
    chk("reset", "bp_val", bp_val, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle", "rdy_in", 32'(curPipReadyToRcv), 32'd0);
    startSig = 1'b1;
    step();
    startSig = 1'b0;

    // Directed scenarios
    do_op("alu",   1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0, 0);
    do_op("lb",    1'b1, 5'd7, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 3, 32'h80FF_FFFF, 0);
    do_op("lbu",   1'b1, 5'd7, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 3, 32'h80FF_FFFF, 0);
    do_op("sh",    1'b1, 5'd3, 32'h102, 32'hABCD, 1'b0, 1'b1, 2'd1, 1'b0, 2, 32'h0, 0);
    do_op("lw_mis",1'b1, 5'd9, 32'h101, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1, 32'h0, 0);
    do_op("stall", 1'b1, 5'd4, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0, 4);
    do_op("lh_r0", 1'b1, 5'd0, 32'h206, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1, 32'h8001_1234, 1);

    // startSig and mem_ack outside their states have no effect
    startSig = 1'b1; mem_ack = 1'b1;
    step();
    startSig = 1'b0; mem_ack = 1'b0;
    chk("stray", "rdy_in", 32'(curPipReadyToRcv), 32'd1);
    chk("stray", "mem_req", 32'(mem_req), 32'd0);
    chk("stray", "rdy_send", 32'(curPipReadyToSend), 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [1:0] sz;
      logic [31:0] addr;
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 2));
      addr = 32'h1000 + 32'($urandom_range(0, 255));
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            (kind == 0) ? $urandom : addr, $urandom, kind == 1, kind == 2, sz,
            1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), $urandom,
            int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an access
    ex_valid = 1'b1; ex_idx = 5'd6; ex_val = 32'h200; ex_isLoad = 1'b1; ex_isStore = 1'b0;
    ex_size = 2'd2; beforePipReadyToSend = 1'b1;
    step();
    beforePipReadyToSend = 1'b0;
    chk("rst_acc", "mem_req_on", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_acc", "mem_req_drop", 32'(mem_req), 32'd0);
    chk("rst_acc", "rdy_in", 32'(curPipReadyToRcv), 32'd0);
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rst_acc", "late_ack_req", 32'(mem_req), 32'd0);
    chk("rst_acc", "late_ack_rdy", 32'({curPipReadyToSend, curPipReadyToRcv}), 32'd0);
    chk("rst_acc", "late_ack_wbv", 32'(wb_valid), 32'd0);
    startSig = 1'b1;
    step();
    startSig = 1'b0;
    chk("rst_acc", "restart", 32'(curPipReadyToRcv), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; REG_IDX, default 5, register index width.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset, with ports listed as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-003 Pipeline control ports SHALL be:
- startSig  in  1  pipeline start pulse.
- beforePipReadyToSend  in  1  execute stage holds a valid op.
- nextPipReadyToRcv  in  1  writeBack accepts.
- curPipReadyToRcv  out  1  this stage accepts an op.
- curPipReadyToSend  out  1  this stage holds a result for writeBack.
REQ-004 Execute-side inputs SHALL be:
- ex_valid  in  1  op writes a register.
- ex_idx  in  REG_IDX  destination index.
- ex_val  in  XLEN  ALU result or effective address.
- ex_storeData  in  XLEN  store source.
- ex_isLoad  in  1  load op.
- ex_isStore  in  1  store op.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word.
- ex_unsigned  in  1  zero-extend loads.
REQ-005 Data-memory ports SHALL be:
- mem_req  out  1  memory access request.
- mem_we  out  1  write request.
- mem_addr  out  XLEN  word-aligned address.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_wstrb  out  4  byte write enables.
- mem_ack  in  1  access complete.
- mem_rdata  in  XLEN  read word.
REQ-006 WriteBack-side and status ports SHALL be:
- wb_valid  out  1  result writes a register.
- wb_idx  out  REG_IDX  destination index.
- wb_val  out  XLEN  result value.
- wb_en_valid, wb_en_idx, wb_en_data  out  1 each  capture strobes.
- bp_idx  out  REG_IDX  bypass index.
- bp_val  out  XLEN  bypass value.
- misalign  out  1  misaligned-access pulse.

Function
REQ-007 The FSM SHALL use states IDLE, WAIT_BEF, ACCESS, SENDING and WAIT_SEND.
REQ-008 The FSM SHALL take these transitions:
- From IDLE, startSig SHALL go to WAIT_BEF.
- From WAIT_BEF, a capture SHALL go to ACCESS for an aligned load or store, otherwise to SENDING.
- ACCESS SHALL hold until mem_ack, then go to SENDING.
- From SENDING or WAIT_SEND with nextPipReadyToRcv: a simultaneous capture SHALL follow the WAIT_BEF rule; otherwise the FSM SHALL go to WAIT_BEF.
- SENDING or WAIT_SEND without nextPipReadyToRcv SHALL go to WAIT_SEND.
REQ-009 curPipReadyToRcv SHALL equal (state==WAIT_BEF) | ((state==SENDING|state==WAIT_SEND) & nextPipReadyToRcv).
REQ-010 curPipReadyToSend SHALL equal (state==SENDING|state==WAIT_SEND).
REQ-011 A capture SHALL occur when curPipReadyToRcv & beforePipReadyToSend; all ex_* inputs SHALL be registered on capture.
REQ-012 A handoff SHALL occur when curPipReadyToSend & nextPipReadyToRcv; wb_en_valid, wb_en_idx and wb_en_data SHALL all equal the handoff signal.
REQ-013 mem_req SHALL be asserted only in ACCESS, with mem_addr/mem_we/mem_wdata/mem_wstrb held stable until mem_ack.
REQ-014 mem_addr SHALL be {ex_val[XLEN-1:2],2'b00}.
REQ-015 mem_wstrb SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word, and 0000 when not storing.
REQ-016 mem_wdata SHALL replicate the store byte or half across lanes.
REQ-017 Load result SHALL be the lane selected by addr[1:0], sign- or zero-extended per ex_unsigned, registered on the mem_ack cycle; non-memory ops SHALL pass ex_val as the result.
REQ-018 A store SHALL force wb_valid=0.
REQ-019 Half at odd address or word at addr[1:0]!=0 SHALL be misaligned:
- no ACCESS state is entered;
- misalign pulses one cycle at capture;
- the op passes to SENDING with wb_valid=0.
REQ-020 bp_idx/bp_val SHALL carry the registered idx/val only when curPipReadyToSend & wb_valid & idx!=0, else zero.
REQ-021 A load result SHALL not appear on bp_* before mem_ack.
REQ-022 A mem_ack outside ACCESS SHALL be ignored.
REQ-023 startSig while not IDLE SHALL be ignored.

Reset
REQ-024 On rst the FSM SHALL enter IDLE.
REQ-025 On rst every output SHALL be 0: mem_req, mem_we, mem_wstrb, wb_valid, wb_en_*, misalign, curPipReadyToSend, curPipReadyToRcv, bp_*.
REQ-026 Reset during ACCESS SHALL abandon the request, with mem_req low in the same cycle; a late mem_ack SHALL be ignored.

Structure
REQ-027 FSM state encodings and the size codes (BYTE=00, HALF=01, WORD=10) SHALL live in a shared package.
REQ-028 Load lane extraction and extension SHALL be one combinational sub-module, load_align.

Verification
REQ-029 ALU op ex_idx=5, ex_val=0x1234, next ready -> SENDING 1 cycle after capture; wb_en_* pulse; wb_val=0x1234; bp_idx=5.
REQ-030 LB addr 0x103, rdata 0x80FFFFFF, ack after 3 cycles -> mem_req high 3 cycles; wb_val=0xFFFFFF80.
REQ-031 LBU, same stimulus -> wb_val=0x00000080.
REQ-032 SH addr 0x102, data 0xABCD -> wstrb=1100, wdata=0xABCDABCD, wb_valid=0.
REQ-033 LW addr 0x101 -> misalign pulse, mem_req never high, wb_valid=0.
REQ-034 nextPipReadyToRcv low 4 cycles -> WAIT_SEND held, outputs stable, no wb_en.
REQ-035 rst mid-ACCESS -> mem_req drops immediately, FSM in IDLE, later ack ignored.
